placement_check: RTL and testbench
==================================

Name: placement_check

Overview:
- Post-placement checker and wirelength reporter, downstream of the 1-hop placement engine.
- Consumes the placement engine's final pos_X/pos_Y/grid RAM contents and the same edge ROMs (ea/eb).
- Phase 1 verifies legality: every node is placed, on the grid, and the grid maps back to it.
- Phase 2 computes per-edge Manhattan metrics: total, 1-hop total, max, and a distance histogram.

Parameters:
- N, 9, grid side; cell address = x*N+y.
- N_NODES, 11, node count; nodes are 0..N_NODES-1.
- N_EDGE, 76, edge count; edges are 0..N_EDGE-1.
- W, 32, data and address width (signed).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of run
- reE  out  1  edge ROM read enable, shared by ea and eb
- addrE  out  W  edge index
- dinA  in  W  ea data
- dinB  in  W  eb data
- reP  out  1  pos RAM read enable, shared by X and Y
- addrP  out  W  node index
- dinPX  in  W  pos_X data
- dinPY  in  W  pos_Y data
- reG  out  1  grid RAM read enable
- addrG  out  W  grid cell address
- dinG  in  W  grid data (node id, or -1 if empty)
- legal  out  1  run completed with no error
- err_code  out  2  0 ok, 1 unplaced, 2 off-grid, 3 grid mismatch
- err_node  out  W  node that caused the error
- total  out  W  sum over edges of (dist-1)
- total_1hop  out  W  sum over edges of (ceil(|dx|/2)+ceil(|dy|/2)-1)
- max_dist  out  W  largest edge dist
- h1, h2, hlong  out  W each  edge counts with dist==1, dist==2, dist>=3

Behaviour:
- Clock and reset: clk and reset as stated in Ports; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE.
- Memory timing: all memory control outputs are registered. Memory data is valid in the cycle after the cycle in which its read enable is high, so each read costs an issue state plus one WAIT state.
- Read enables: each enable is high for exactly one cycle per read.
- Start: in IDLE, a start pulse clears legal, err_code, err_node, total, total_1hop, max_dist and the histograms, sets busy, and sets k=0.
- S_NODE_RD: issue reP at addrP=k.
- S_NODE_CK: node is placed at x=dinPX, y=dinPY.
  - x==-1 or y==-1 -> error 1.
  - x or y outside [0,N-1] -> error 2.
  - Otherwise register cell = x*N+y.
- S_GRID_RD: issue reG at addrG=cell.
- S_GRID_CK: dinG!=k -> error 3. Otherwise k++. When k==N_NODES go to edge phase with i=0; else return to S_NODE_RD.
- S_EDGE_RD: issue reE at addrE=i; latch a=dinA, b=dinB.
- S_PA_RD / S_PB_RD: read the position of a, then of b, through the shared pos port; latch xa, ya, xb, yb.
- S_DIFF: dx=|xa-xb|, dy=|ya-yb|, in two's-complement signed arithmetic.
- S_ACC: d=dx+dy.
  - total += d-1.
  - total_1hop += (dx>>1)+dx[0]+(dy>>1)+dy[0]-1.
  - max_dist = max(max_dist, d).
  - Bump h1, h2 or hlong by d.
  - d==0 (two endpoints on the same cell) cannot occur after a legal phase 1; it counts into none of the histograms.
  - i++. When i==N_EDGE: legal=1 and go to DONE.
- Error path: on the first error, latch err_code and err_node=k, keep legal=0, and go to DONE; the edge phase is skipped.
- DONE: done=1 for one cycle, busy=0, then IDLE. Result outputs hold until the next accepted start or reset.
- Reset mid-run: the state machine aborts immediately and all outputs return to 0. Memories are not written by this block.
- Start handling: start while busy is ignored. A start in the same cycle as done is ignored; start is accepted only in IDLE.
- Arithmetic: totals are W-bit and wrap silently; no saturation.
- Cycle count, legal run: 5*N_NODES + 10*N_EDGE + 2 cycles from start to done (node loop 5 cycles/node; edge loop 10 cycles/edge).

Test Plan:
- N=3, N_NODES=2, N_EDGE=1. Node0 at (0,0), node1 at (0,1); grid[0]=0, grid[1]=1; edge 0-1 -> legal=1, total=0, total_1hop=0, max_dist=1, h1=1, done after 22 cycles.
- Node1 at (2,2), grid[8]=1, same edge -> total=3, total_1hop=1, max_dist=4, hlong=1.
- pos_X[1]=-1 -> err_code=1, err_node=1, legal=0; reE never asserted.
- Node0 at (3,0) with N=3 -> err_code=2, err_node=0.
- grid[1]=0 while node1 sits at (0,1) -> err_code=3, err_node=1.
- Assert reset 3 cycles into a run -> all outputs 0 asynchronously; a fresh start then completes normally. Also a second start pulse while busy -> no effect on the result.

Source files
------------

// File: rtl/placement_check_if.sv
// Start/done handshake, edge/pos/grid read ports and result bus of placement_check.
interface placement_check_if #(parameter int W = 32);
  logic                start, busy, done;
  logic                reE, reP, reG;
  logic [W-1:0]        addrE, addrP, addrG;
  logic signed [W-1:0] dinA, dinB, dinPX, dinPY, dinG;
  logic                legal;
  logic [1:0]          err_code;
  logic [W-1:0]        err_node, total, total_1hop, max_dist, h1, h2, hlong;

  modport master (
    input  start, dinA, dinB, dinPX, dinPY, dinG,
    output busy, done, reE, addrE, reP, addrP, reG, addrG,
           legal, err_code, err_node, total, total_1hop, max_dist, h1, h2, hlong
  );
  modport slave (
    output start, dinA, dinB, dinPX, dinPY, dinG,
    input  busy, done, reE, addrE, reP, addrP, reG, addrG,
           legal, err_code, err_node, total, total_1hop, max_dist, h1, h2, hlong
  );
endinterface

// File: rtl/placement_check.sv
// Post-placement legality checker and edge wirelength reporter.
// Reads: enable registered in the issue state, high in the next, data valid one cycle later.
module placement_check #(
  parameter int N       = 9,
  parameter int N_NODES = 11,
  parameter int N_EDGE  = 76,
  parameter int W       = 32
) (
  input  logic           clk,
  input  logic           reset,
  placement_check_if.master bus
);
  typedef enum logic [4:0] {
    S_IDLE, S_NODE_RD, S_NODE_WAIT, S_NODE_CK, S_GRID_WAIT, S_GRID_CK,
    S_EDGE_RD, S_EDGE_WAIT, S_EDGE_CK, S_PA_RD, S_PA_WAIT, S_PB_RD,
    S_PB_WAIT, S_PB_CK, S_DIFF, S_ACC, S_DONE
  } state_t;

  localparam logic signed [W-1:0] LIM       = W'(N - 1);
  localparam logic [W-1:0]        NW        = W'(N);
  localparam logic [W-1:0]        LAST_NODE = W'(N_NODES - 1);
  localparam logic [W-1:0]        LAST_EDGE = W'(N_EDGE - 1);
  localparam logic [W-1:0]        ONE       = W'(1);
  localparam logic signed [W-1:0] TWO       = W'(2);

  state_t state, nxt;
  logic busy, done;

  logic                re_e, re_p, re_g;
  logic [W-1:0]        addr_e, addr_p, addr_g;
  logic [W-1:0]        k, i, a, b;
  logic signed [W-1:0] xa, ya, xb, yb, dx, dy;
  logic                legal;
  logic [1:0]          code;
  logic [W-1:0]        enode, tot, tot1, c1, c2, cl;
  logic signed [W-1:0] mx;

  logic signed [W-1:0] px, py, diff_x, diff_y, d;
  logic [W-1:0]        hop;
  logic                unplaced, offgrid, grid_bad;

  assign px       = bus.dinPX;
  assign py       = bus.dinPY;
  assign unplaced = (px == '1) || (py == '1);
  assign offgrid  = px[W-1] || py[W-1] || (px > LIM) || (py > LIM);
  assign grid_bad = (bus.dinG != k);
  assign diff_x   = xa - xb;
  assign diff_y   = ya - yb;
  assign d        = dx + dy;
  // ceil(|dx|/2)+ceil(|dy|/2)-1: hops needed when each move may cover two cells
  assign hop      = (dx >> 1) + W'(dx[0]) + (dy >> 1) + W'(dy[0]) - ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      if (bus.start) nxt = S_NODE_RD;
      S_NODE_RD:   nxt = S_NODE_WAIT;
      S_NODE_WAIT: nxt = S_NODE_CK;
      S_NODE_CK:   nxt = (unplaced || offgrid) ? S_DONE : S_GRID_WAIT;
      S_GRID_WAIT: nxt = S_GRID_CK;
      S_GRID_CK:   nxt = grid_bad ? S_DONE : (k == LAST_NODE) ? S_EDGE_RD : S_NODE_RD;
      S_EDGE_RD:   nxt = S_EDGE_WAIT;
      S_EDGE_WAIT: nxt = S_EDGE_CK;
      S_EDGE_CK:   nxt = S_PA_RD;
      S_PA_RD:     nxt = S_PA_WAIT;
      S_PA_WAIT:   nxt = S_PB_RD;
      S_PB_RD:     nxt = S_PB_WAIT;
      S_PB_WAIT:   nxt = S_PB_CK;
      S_PB_CK:     nxt = S_DIFF;
      S_DIFF:      nxt = S_ACC;
      S_ACC:       nxt = (i == LAST_EDGE) ? S_DONE : S_EDGE_RD;
      S_DONE:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_IDLE:  ;
      S_DONE:  done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      re_e <= 1'b0; re_p <= 1'b0; re_g <= 1'b0;
      addr_e <= '0; addr_p <= '0; addr_g <= '0;
      k <= '0; i <= '0; a <= '0; b <= '0;
      xa <= '0; ya <= '0; xb <= '0; yb <= '0; dx <= '0; dy <= '0;
      legal <= 1'b0; code <= 2'd0; enode <= '0;
      tot <= '0; tot1 <= '0; mx <= '0; c1 <= '0; c2 <= '0; cl <= '0;
    end else begin
      re_e <= 1'b0;
      re_p <= 1'b0;
      re_g <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          legal <= 1'b0; code <= 2'd0; enode <= '0;
          tot <= '0; tot1 <= '0; mx <= '0; c1 <= '0; c2 <= '0; cl <= '0;
          k <= '0;
        end
        S_NODE_RD: begin re_p <= 1'b1; addr_p <= k; end
        S_NODE_CK: begin
          if (unplaced)     begin code <= 2'd1; enode <= k; end
          else if (offgrid) begin code <= 2'd2; enode <= k; end
          else begin re_g <= 1'b1; addr_g <= px * NW + py; end
        end
        S_GRID_CK: begin
          if (grid_bad) begin code <= 2'd3; enode <= k; end
          else begin k <= k + ONE; i <= '0; end
        end
        S_EDGE_RD: begin re_e <= 1'b1; addr_e <= i; end
        S_EDGE_CK: begin a <= bus.dinA; b <= bus.dinB; end
        S_PA_RD:   begin re_p <= 1'b1; addr_p <= a; end
        S_PB_RD:   begin xa <= px; ya <= py; re_p <= 1'b1; addr_p <= b; end
        S_PB_CK:   begin xb <= px; yb <= py; end
        S_DIFF: begin
          dx <= diff_x[W-1] ? -diff_x : diff_x;
          dy <= diff_y[W-1] ? -diff_y : diff_y;
        end
        S_ACC: begin
          tot  <= tot + d - ONE;
          tot1 <= tot1 + hop;
          if (d > mx) mx <= d;
          // d==0 is unreachable after a legal node phase and lands in no bin
          if (d == ONE)      c1 <= c1 + ONE;
          else if (d == TWO) c2 <= c2 + ONE;
          else if (d > TWO)  cl <= cl + ONE;
          i <= i + ONE;
          if (i == LAST_EDGE) legal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.reE        = re_e;
  assign bus.addrE      = addr_e;
  assign bus.reP        = re_p;
  assign bus.addrP      = addr_p;
  assign bus.reG        = re_g;
  assign bus.addrG      = addr_g;
  assign bus.legal      = legal;
  assign bus.err_code   = code;
  assign bus.err_node   = enode;
  assign bus.total      = tot;
  assign bus.total_1hop = tot1;
  assign bus.max_dist   = mx;
  assign bus.h1         = c1;
  assign bus.h2         = c2;
  assign bus.hlong      = cl;
endmodule

// File: tb/tb_placement_check.sv
// Directed bench for placement_check on a 3x3 grid, two nodes, one edge.
module tb_placement_check;
  localparam int N = 3, NN = 2, NE = 1, W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  placement_check_if #(.W(W)) bus ();
  placement_check #(.N(N), .N_NODES(NN), .N_EDGE(NE), .W(W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic signed [W-1:0] pos_x [16];
  logic signed [W-1:0] pos_y [16];
  logic signed [W-1:0] grid  [16];
  logic signed [W-1:0] ea    [4];
  logic signed [W-1:0] eb    [4];
  int n_rep = 0, n_reg = 0, n_ree = 0;

  // memories: data valid the cycle after the enable cycle
  always @(posedge clk) begin
    if (bus.reP) begin
      bus.dinPX <= pos_x[bus.addrP[3:0]];
      bus.dinPY <= pos_y[bus.addrP[3:0]];
      n_rep <= n_rep + 1;
    end
    if (bus.reG) begin
      bus.dinG <= grid[bus.addrG[3:0]];
      n_reg <= n_reg + 1;
    end
    if (bus.reE) begin
      bus.dinA <= ea[bus.addrE[1:0]];
      bus.dinB <= eb[bus.addrE[1:0]];
      n_ree <= n_ree + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // lat = cycles from the start cycle to the done cycle, both inclusive
  task automatic run(input bit dbl, input bit start_at_done, output int lat);
    int cyc;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 1;
    chk("busy_after_start", W'(bus.busy), 1);
    while (!bus.done && cyc < 300) begin
      bus.start = dbl && (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_seen", W'(bus.done), 1);
    chk("busy_at_done", W'(bus.busy), 0);
    if (start_at_done) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_at_done_ignored", W'(bus.busy), 0);
    end
    lat = cyc + 1;
  endtask

  task automatic set_default();
    for (int j = 0; j < 16; j++) begin
      pos_x[j] = '1; pos_y[j] = '1; grid[j] = '1;
    end
    pos_x[0] = 0; pos_y[0] = 0;
    pos_x[1] = 0; pos_y[1] = 1;
    grid[0] = 0; grid[1] = 1;
    for (int j = 0; j < 4; j++) begin ea[j] = 0; eb[j] = 1; end
  endtask

  initial begin
    int lat, p0, g0, e0;
    bus.start = 1'b0;
    set_default();
    reset = 1'b1;
    #1;
    chk("rst_busy", W'(bus.busy), 0);
    chk("rst_done", W'(bus.done), 0);
    chk("rst_legal", W'(bus.legal), 0);
    chk("rst_re", W'({bus.reE, bus.reP, bus.reG}), 0);
    chk("rst_total", bus.total, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // T1: adjacent nodes, legal
    p0 = n_rep; g0 = n_reg; e0 = n_ree;
    run(1'b0, 1'b0, lat);
    chk("t1_lat", W'(lat), 22);
    chk("t1_legal", W'(bus.legal), 1);
    chk("t1_code", W'(bus.err_code), 0);
    chk("t1_total", bus.total, 0);
    chk("t1_1hop", bus.total_1hop, 0);
    chk("t1_max", bus.max_dist, 1);
    chk("t1_h1", bus.h1, 1);
    chk("t1_h2", bus.h2, 0);
    chk("t1_hlong", bus.hlong, 0);
    chk("t1_reP_pulses", W'(n_rep - p0), 4);
    chk("t1_reG_pulses", W'(n_reg - g0), 2);
    chk("t1_reE_pulses", W'(n_ree - e0), 1);

    // T2: node1 in far corner, stray start while busy and at done
    pos_x[1] = 2; pos_y[1] = 2; grid[1] = '1; grid[8] = 1;
    run(1'b1, 1'b1, lat);
    chk("t2_lat", W'(lat), 22);
    chk("t2_legal", W'(bus.legal), 1);
    chk("t2_total", bus.total, 3);
    chk("t2_1hop", bus.total_1hop, 1);
    chk("t2_max", bus.max_dist, 4);
    chk("t2_h1", bus.h1, 0);
    chk("t2_hlong", bus.hlong, 1);

    // T3: node1 unplaced
    set_default();
    pos_x[1] = '1;
    e0 = n_ree;
    run(1'b0, 1'b0, lat);
    chk("t3_lat", W'(lat), 10);
    chk("t3_code", W'(bus.err_code), 1);
    chk("t3_node", bus.err_node, 1);
    chk("t3_legal", W'(bus.legal), 0);
    chk("t3_total_cleared", bus.total, 0);
    chk("t3_no_reE", W'(n_ree - e0), 0);

    // T4: node0 off-grid at x=N
    set_default();
    pos_x[0] = 3;
    run(1'b0, 1'b0, lat);
    chk("t4_lat", W'(lat), 5);
    chk("t4_code", W'(bus.err_code), 2);
    chk("t4_node", bus.err_node, 0);

    // T5: grid cell of node1 points at node0
    set_default();
    grid[1] = 0;
    run(1'b0, 1'b0, lat);
    chk("t5_lat", W'(lat), 12);
    chk("t5_code", W'(bus.err_code), 3);
    chk("t5_node", bus.err_node, 1);
    chk("t5_legal", W'(bus.legal), 0);

    // T6: reset 3 cycles into a run, then a clean run
    set_default();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_busy_before_rst", W'(bus.busy), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", W'(bus.busy), 0);
    chk("t6_rst_code", W'(bus.err_code), 0);
    chk("t6_rst_re", W'({bus.reE, bus.reP, bus.reG}), 0);
    @(negedge clk);
    chk("t6_rst_hold_re", W'({bus.reE, bus.reP, bus.reG}), 0);
    reset = 1'b0;
    run(1'b0, 1'b0, lat);
    chk("t6_lat", W'(lat), 22);
    chk("t6_legal", W'(bus.legal), 1);
    chk("t6_h1", bus.h1, 1);
    repeat (3) @(negedge clk);
    chk("t6_hold_legal", W'(bus.legal), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
